router_fsm: RTL and testbench
=============================

# router_fsm

Packet-sequencing controller for the 1x3 router. It sits between the input interface and the register/synchronizer datapath, and decodes the header address. It steps each packet through these phases:

- header load
- payload load
- full-stall
- parity load
- parity check

It drives the load strobes, `busy` back-pressure, `write_enb_reg` and `detect_add`, which the synchronizer uses to latch the destination and steer writes into one of three FIFOs.

## Interface
Parameters: none (state encoding is internal, 3 bits).

Ports:
- `clock`  input  1  system clock; all state updates on the rising edge
- `resetn`  input  1  asynchronous active-low reset
- `pkt_valid`  input  1  packet byte valid on input bus; deasserts on the parity byte
- `data_in`  input  2  header address bits [1:0]; 0/1/2 select FIFO, 3 is invalid
- `fifo_full`  input  1  selected FIFO full (from synchronizer)
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2`  input  1 each  per-FIFO empty flags
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2`  input  1 each  per-FIFO read-timeout soft reset
- `parity_done`  input  1  parity byte captured by the register block
- `low_pkt_valid`  input  1  `pkt_valid` fell while stalled (register block flag)
- `busy`  output  1  stall input source
- `detect_add`  output  1  latch header address
- `lfd_state`  output  1  load-first-data (header) phase
- `ld_state`  output  1  payload load phase
- `laf_state`  output  1  load-after-full phase
- `full_state`  output  1  FIFO-full stall phase
- `write_enb_reg`  output  1  write enable to synchronizer
- `rst_int_reg`  output  1  parity check / clear internal parity register

## Operation
- Moore machine: one state register. All outputs decode combinationally from the current state only.
- A 2-bit `addr_q` captures `data_in` in DECODE_ADDRESS when `pkt_valid`=1. It selects the `fifo_empty_n` / `soft_reset_n` pair used by later states.

States, their asserted outputs (all others 0), and next-state rules:
- DECODE_ADDRESS: `detect_add`.
  - `pkt_valid` and `data_in`≠3 and `fifo_empty[data_in]` → LOAD_FIRST_DATA.
  - `pkt_valid` and `data_in`≠3 and not empty → WAIT_TILL_EMPTY.
  - Otherwise stay.
- WAIT_TILL_EMPTY: `busy`. `fifo_empty[addr_q]` → LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: `lfd_state`, `busy`. → LOAD_DATA unconditionally.
- LOAD_DATA: `ld_state`, `write_enb_reg`.
  - `fifo_full` → FIFO_FULL_STATE.
  - else `!pkt_valid` → LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: `full_state`, `busy`. `!fifo_full` → LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: `laf_state`, `busy`, `write_enb_reg`.
  - `parity_done` → DECODE_ADDRESS.
  - else `low_pkt_valid` → LOAD_PARITY.
  - else → LOAD_DATA.
- LOAD_PARITY: `busy`, `write_enb_reg`. → CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: `rst_int_reg`, `busy`. `fifo_full` → FIFO_FULL_STATE; else → DECODE_ADDRESS.

Soft reset:
- `soft_reset[addr_q]`=1 in any state other than DECODE_ADDRESS forces next state DECODE_ADDRESS, overriding all transitions above.
- Soft resets for non-selected FIFOs are ignored.

Other rules:
- Address 3 is never accepted. The machine idles in DECODE_ADDRESS and `addr_q` is not updated.
- Async reset mid-packet: state goes to DECODE_ADDRESS and `addr_q` to 0 immediately. Outputs follow the DECODE_ADDRESS decode.

## Timing
- Reset values:
  - `detect_add`=1.
  - `busy`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `write_enb_reg`, `rst_int_reg`=0.
  - `addr_q`=0.
- An input sampled at edge N changes outputs after edge N (combinational decode of the new state). There is no additional pipeline stage.
- Header cycle: `pkt_valid` with a valid address at edge N → `lfd_state`=1 for exactly one cycle after N, then `ld_state` from edge N+1.
- Parity: `pkt_valid` low in LOAD_DATA at edge N → LOAD_PARITY for one cycle, then CHECK_PARITY_ERROR for one cycle.
- `busy` is 1 in every state except DECODE_ADDRESS and LOAD_DATA.

## Configuration
- `ROUTER_FSM_WAIT_EMPTY_EN` defined: WAIT_TILL_EMPTY exists as above. A packet never enters a non-empty destination FIFO.
- Not defined: WAIT_TILL_EMPTY is removed. DECODE_ADDRESS goes to LOAD_FIRST_DATA on `pkt_valid` with `data_in`≠3, regardless of the `fifo_empty_n` flags, which are unused. Packets queue behind prior packets.

## Test plan
- Reset: `resetn`=0 mid-LOAD_DATA → next cycle `detect_add`=1, all other outputs 0, state DECODE_ADDRESS.
- Clean packet: `data_in`=2, `fifo_empty_2`=1, `pkt_valid` for 4 cycles then 0 → `lfd_state` 1 cycle, `ld_state` 3 cycles, then LOAD_PARITY (`busy`=1, `write_enb_reg`=1), then `rst_int_reg`=1, then `detect_add`=1.
- Full stall: `fifo_full`=1 during LOAD_DATA → `full_state`=1 with `write_enb_reg`=0. Then `fifo_full`=0 and `low_pkt_valid`=1 → `laf_state` 1 cycle, then LOAD_PARITY.
- Wait-empty (macro on): `data_in`=1, `fifo_empty_1`=0 for 5 cycles → `busy`=1, no `lfd_state`. `fifo_empty_1`=1 → `lfd_state` next cycle. Macro off → `lfd_state` immediately.
- Soft reset: in LOAD_DATA with `addr_q`=0, pulse `soft_reset_1` → no effect. Pulse `soft_reset_0` → `detect_add`=1 next cycle.
- Invalid address: `data_in`=3 with `pkt_valid`=1 for 4 cycles → stays DECODE_ADDRESS, `busy`=0, `addr_q` unchanged.

Source files
------------

// File: rtl/router_fsm_if.sv
// Handshake and status bundle between the router input side, the
// register/synchronizer datapath and the packet-sequencing FSM.
// master: drives the packet/status inputs (input side, datapath, bench).
// slave : the router_fsm itself.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;

  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;

  modport master (
    output pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    input  busy, detect_add, lfd_state, ld_state, laf_state,
           full_state, write_enb_reg, rst_int_reg
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    output busy, detect_add, lfd_state, ld_state, laf_state,
           full_state, write_enb_reg, rst_int_reg
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router (Moore machine).
// Optional feature macro: ROUTER_FSM_WAIT_EMPTY_EN
//   defined   : a packet waits in WAIT_TILL_EMPTY until its destination
//               FIFO is empty.
//   undefined : WAIT_TILL_EMPTY is unreachable, fifo_empty_* are unused and
//               packets queue behind earlier ones in the destination FIFO.
//
// state              | meaning
// -------------------+-----------------------------------------------
// DECODE_ADDRESS     | idle, latch header address on pkt_valid
// WAIT_TILL_EMPTY    | destination FIFO not empty, stall input
// LOAD_FIRST_DATA    | write header byte
// LOAD_DATA          | stream payload bytes
// FIFO_FULL_STATE    | destination full, stall input
// LOAD_AFTER_FULL    | write the byte held during the stall
// LOAD_PARITY        | write parity byte
// CHECK_PARITY_ERROR | compare parity, clear internal parity register
module router_fsm (
  input  logic         clock,
  input  logic         resetn,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       soft_sel;
  logic       addr_ok;

`ifdef ROUTER_FSM_WAIT_EMPTY_EN
  logic       empty_hdr;
  logic       empty_sel;

  // Empty flag of the FIFO addressed by the incoming header and by addr_q.
  always_comb begin
    empty_hdr = 1'b0;
    empty_sel = 1'b0;
    case (bus.data_in)
      2'd0:    empty_hdr = bus.fifo_empty_0;
      2'd1:    empty_hdr = bus.fifo_empty_1;
      2'd2:    empty_hdr = bus.fifo_empty_2;
      default: empty_hdr = 1'b0;
    endcase
    case (addr_q)
      2'd0:    empty_sel = bus.fifo_empty_0;
      2'd1:    empty_sel = bus.fifo_empty_1;
      2'd2:    empty_sel = bus.fifo_empty_2;
      default: empty_sel = 1'b0;
    endcase
  end
`endif

  // Soft reset of the latched destination only; other FIFOs are ignored.
  always_comb begin
    soft_sel = 1'b0;
    case (addr_q)
      2'd0:    soft_sel = bus.soft_reset_0;
      2'd1:    soft_sel = bus.soft_reset_1;
      2'd2:    soft_sel = bus.soft_reset_2;
      default: soft_sel = 1'b0;
    endcase
  end

  assign addr_ok = bus.pkt_valid && (bus.data_in != 2'd3);

  // State and destination address registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and address-capture logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (addr_ok) begin
          addr_d = bus.data_in;
`ifdef ROUTER_FSM_WAIT_EMPTY_EN
          state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`else
          state_d = LOAD_FIRST_DATA;
`endif
        end
      end
      WAIT_TILL_EMPTY: begin
`ifdef ROUTER_FSM_WAIT_EMPTY_EN
        if (empty_sel) state_d = LOAD_FIRST_DATA;
`else
        state_d = DECODE_ADDRESS;
`endif
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    if ((state_q != DECODE_ADDRESS) && soft_sel) state_d = DECODE_ADDRESS;
  end

  // Moore output decode from the current state.
  always_comb begin
    bus.busy          = 1'b0;
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.rst_int_reg   = 1'b0;
    case (state_q)
      DECODE_ADDRESS:  bus.detect_add = 1'b1;
      WAIT_TILL_EMPTY: bus.busy = 1'b1;
      LOAD_FIRST_DATA: begin
        bus.lfd_state = 1'b1;
        bus.busy      = 1'b1;
      end
      LOAD_DATA: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        bus.full_state = 1'b1;
        bus.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        bus.laf_state     = 1'b1;
        bus.busy          = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        bus.busy          = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        bus.rst_int_reg = 1'b1;
        bus.busy        = 1'b1;
      end
      default: bus.detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: each step queues the expected
// output vector and address; a monitor compares after every rising edge.
module tb_router_fsm;

  // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
  localparam logic [7:0] DA  = 8'b0100_0000;
  localparam logic [7:0] WTE = 8'b1000_0000;
  localparam logic [7:0] LFD = 8'b1010_0000;
  localparam logic [7:0] LD  = 8'b0001_0010;
  localparam logic [7:0] FFS = 8'b1000_0100;
  localparam logic [7:0] LAF = 8'b1000_1010;
  localparam logic [7:0] LP  = 8'b1000_0010;
  localparam logic [7:0] CPE = 8'b1000_0001;

  typedef struct {
    logic [7:0] outs;
    logic [1:0] addr;
    string      name;
  } exp_t;

  logic   clock;
  logic   resetn;
  exp_t   sb[$];
  exp_t   e_m;
  int     n_vec;
  int     n_bad;
  logic [7:0] act;

  router_fsm_if bus ();

  router_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign act = {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                bus.laf_state, bus.full_state, bus.write_enb_reg, bus.rst_int_reg};

  // Monitor: compare queued expectation against outputs after each edge.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      e_m = sb.pop_front();
      n_vec++;
      if (act !== e_m.outs || dut.addr_q !== e_m.addr) begin
        n_bad++;
        $display("FAIL %s: outs=%b addr=%0d, required outs=%b addr=%0d",
                 e_m.name, act, dut.addr_q, e_m.outs, e_m.addr);
      end
    end
  end

  task automatic step(input logic [7:0] o, input logic [1:0] a, input string n);
    exp_t e;
    e.outs = o;
    e.addr = a;
    e.name = n;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    resetn = 1'b0;
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'd0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty_0  = 1'b1;
    bus.fifo_empty_1  = 1'b1;
    bus.fifo_empty_2  = 1'b1;
    bus.soft_reset_0  = 1'b0;
    bus.soft_reset_1  = 1'b0;
    bus.soft_reset_2  = 1'b0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    step(DA, 2'd0, "reset_state");

    // Clean packet to FIFO 2
    bus.data_in = 2'd2; bus.pkt_valid = 1'b1;
    step(LFD, 2'd2, "clean_hdr");
    step(LD,  2'd2, "clean_ld1");
    step(LD,  2'd2, "clean_ld2");
    step(LD,  2'd2, "clean_ld3");
    bus.pkt_valid = 1'b0;
    step(LP,  2'd2, "clean_parity");
    step(CPE, 2'd2, "clean_check");
    step(DA,  2'd2, "clean_idle");

    // Full stall, resume via low_pkt_valid, then CHECK->FULL->LAF->DA
    bus.data_in = 2'd0; bus.pkt_valid = 1'b1;
    step(LFD, 2'd0, "full_hdr");
    step(LD,  2'd0, "full_ld");
    bus.fifo_full = 1'b1;
    step(FFS, 2'd0, "full_stall1");
    step(FFS, 2'd0, "full_stall2");
    bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1;
    step(LAF, 2'd0, "full_laf");
    bus.pkt_valid = 1'b0;
    step(LP,  2'd0, "full_parity");
    bus.low_pkt_valid = 1'b0;
    step(CPE, 2'd0, "full_check");
    bus.fifo_full = 1'b1;
    step(FFS, 2'd0, "check_to_full");
    bus.fifo_full = 1'b0;
    step(LAF, 2'd0, "check_laf");
    bus.parity_done = 1'b1;
    step(DA,  2'd0, "laf_parity_done");
    bus.parity_done = 1'b0;

    // LAF back to LD, then soft resets while in LOAD_DATA
    bus.pkt_valid = 1'b1;
    step(LFD, 2'd0, "sr_hdr");
    step(LD,  2'd0, "sr_ld");
    bus.fifo_full = 1'b1;
    step(FFS, 2'd0, "sr_full");
    bus.fifo_full = 1'b0;
    step(LAF, 2'd0, "sr_laf");
    step(LD,  2'd0, "laf_to_ld");
    bus.soft_reset_1 = 1'b1;
    step(LD,  2'd0, "soft_other_ignored");
    bus.soft_reset_1 = 1'b0; bus.soft_reset_0 = 1'b1;
    step(DA,  2'd0, "soft_selected");
    bus.soft_reset_0 = 1'b0; bus.pkt_valid = 1'b0;
    step(DA,  2'd0, "soft_idle");

    // Destination FIFO 1 not empty
    bus.data_in = 2'd1; bus.fifo_empty_1 = 1'b0; bus.pkt_valid = 1'b1;
`ifdef ROUTER_FSM_WAIT_EMPTY_EN
    for (int i = 0; i < 5; i++) step(WTE, 2'd1, "wait_empty");
    bus.fifo_empty_1 = 1'b1;
    step(LFD, 2'd1, "wait_released");
`else
    step(LFD, 2'd1, "no_wait_hdr");
`endif
    step(LD,  2'd1, "we_ld");
    bus.pkt_valid = 1'b0;
    step(LP,  2'd1, "we_parity");
    step(CPE, 2'd1, "we_check");
    step(DA,  2'd1, "we_idle");

    // Invalid address 3
    bus.data_in = 2'd3; bus.pkt_valid = 1'b1; bus.fifo_empty_1 = 1'b1;
    for (int i = 0; i < 4; i++) step(DA, 2'd1, "invalid_addr");
    bus.pkt_valid = 1'b0;

    // Async reset mid-LOAD_DATA
    bus.data_in = 2'd2; bus.pkt_valid = 1'b1;
    step(LFD, 2'd2, "rst_hdr");
    step(LD,  2'd2, "rst_ld");
    resetn = 1'b0;
    step(DA,  2'd0, "rst_mid_packet");
    resetn = 1'b1; bus.pkt_valid = 1'b0;
    step(DA,  2'd0, "rst_release");

    @(negedge clock);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
